// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receive FSM states, frame geometry, default timing
// constants and the scan-code prefixes used by the downstream decoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam int PS2_FRAME_BITS  = 11;
  localparam int FILTER_LEN_DEF  = 16;
  localparam int TIMEOUT_CYC_DEF = 100000;

  localparam logic [7:0] SCAN_BREAK    = 8'hF0;
  localparam logic [7:0] SCAN_EXTENDED = 8'hE0;

  // True when the eight data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a persistence filter: the output only
// follows the input after FILTER_LEN consecutive differing samples.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic raw,
  output logic filtered
);

  localparam int CNT_W = $clog2(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             filt_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Idle PS/2 lines float high, so every stage resets to 1.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      filt_reg  <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      if (sync2_reg == filt_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        filt_reg <= sync2_reg;
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign filtered = filt_reg;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: conditions both lines, deserialises 11-bit
// frames on filtered clock falls and reports good codes or error pulses.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = FILTER_LEN_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] SCAN,
  output logic       SCAN_VALID,
  output logic       PARITY_ERR,
  output logic       FRAME_ERR
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [1:0] raw_lines;
  logic [1:0] filt_lines;

  assign raw_lines = {PS2_DAT, PS2_CLK};

  // Identical filters keep clock and data aligned through the same latency.
  for (genvar gi = 0; gi < 2; gi++) begin : g_filter
    ps2_line_filter #(
      .FILTER_LEN(FILTER_LEN)
    ) u_filter (
      .CLOCK_50(CLOCK_50),
      .RESET_N (RESET_N),
      .raw     (raw_lines[gi]),
      .filtered(filt_lines[gi])
    );
  end

  logic clk_filt;
  logic dat_filt;
  logic fall;

  assign clk_filt = filt_lines[0];
  assign dat_filt = filt_lines[1];

  ps2_state_t       state_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       data_reg;
  logic             parity_reg;
  logic [TMO_W-1:0] tmo_reg;
  logic             clk_prev_reg;
  logic [7:0]       scan_reg;
  logic             scan_valid_reg;
  logic             parity_err_reg;
  logic             frame_err_reg;

  assign fall = clk_prev_reg & ~clk_filt;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg      <= ST_IDLE;
      bit_idx_reg    <= '0;
      data_reg       <= '0;
      parity_reg     <= 1'b0;
      tmo_reg        <= '0;
      clk_prev_reg   <= 1'b1;
      scan_reg       <= 8'h00;
      scan_valid_reg <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      clk_prev_reg   <= clk_filt;
      scan_valid_reg <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;

      if (state_reg == ST_IDLE || fall) begin
        tmo_reg <= '0;
      end else begin
        tmo_reg <= tmo_reg + TMO_W'(1);
      end

      if (state_reg == ST_IDLE) begin
        if (fall && !dat_filt) begin
          state_reg   <= ST_DATA;
          bit_idx_reg <= '0;
        end
      end else if (!fall) begin
        // Device stalled mid-frame: drop the partial frame.
        if (tmo_reg == TMO_LAST) begin
          state_reg     <= ST_IDLE;
          tmo_reg       <= '0;
          frame_err_reg <= 1'b1;
        end
      end else begin
        case (state_reg)
          ST_DATA: begin
            data_reg[bit_idx_reg] <= dat_filt;
            bit_idx_reg           <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            parity_reg <= dat_filt;
            state_reg  <= ST_STOP;
          end
          ST_STOP: begin
            state_reg <= ST_IDLE;
            // A bad stop bit takes precedence over a parity failure.
            if (!dat_filt) begin
              frame_err_reg <= 1'b1;
            end else if (!odd_parity_ok(data_reg, parity_reg)) begin
              parity_err_reg <= 1'b1;
            end else begin
              scan_reg       <= data_reg;
              scan_valid_reg <= 1'b1;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign SCAN       = scan_reg;
  assign SCAN_VALID = scan_valid_reg;
  assign PARITY_ERR = parity_err_reg;
  assign FRAME_ERR  = frame_err_reg;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: table of whole frames plus hand-written
// timeout, glitch and mid-frame reset sequences.
module tb_ps2_rx_frame;

  localparam int FILT = 16;
  localparam int TMO  = 400;
  localparam int LAT  = 20;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic [7:0] SCAN;
  logic       SCAN_VALID;
  logic       PARITY_ERR;
  logic       FRAME_ERR;

  ps2_rx_frame #(
    .FILTER_LEN (FILT),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .SCAN      (SCAN),
    .SCAN_VALID(SCAN_VALID),
    .PARITY_ERR(PARITY_ERR),
    .FRAME_ERR (FRAME_ERR)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks   = 0;
  int failures = 0;

  // Pulse monitor, sampled on the falling edge of CLOCK_50.
  int   cyc = 0;
  int   sv_cnt = 0, pe_cnt = 0, fe_cnt = 0;
  int   sv_cyc = 0, pe_cyc = 0, fe_cyc = 0;
  int   wide_cnt = 0, excl_cnt = 0;
  logic prev_sv = 1'b0, prev_pe = 1'b0, prev_fe = 1'b0;

  always @(negedge CLOCK_50) begin
    cyc = cyc + 1;
    if (SCAN_VALID === 1'b1) begin sv_cnt = sv_cnt + 1; sv_cyc = cyc; end
    if (PARITY_ERR === 1'b1) begin pe_cnt = pe_cnt + 1; pe_cyc = cyc; end
    if (FRAME_ERR  === 1'b1) begin fe_cnt = fe_cnt + 1; fe_cyc = cyc; end
    if ((SCAN_VALID & prev_sv) | (PARITY_ERR & prev_pe) | (FRAME_ERR & prev_fe))
      wide_cnt = wide_cnt + 1;
    if (int'(SCAN_VALID) + int'(PARITY_ERR) + int'(FRAME_ERR) > 1)
      excl_cnt = excl_cnt + 1;
    prev_sv = SCAN_VALID;
    prev_pe = PARITY_ERR;
    prev_fe = FRAME_ERR;
  end

  int last_fall = 0;
  int snap_sv, snap_pe, snap_fe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks = checks + 1;
    if (act < lo || act > hi) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #2;
  endtask

  task automatic snap();
    snap_sv = sv_cnt;
    snap_pe = pe_cnt;
    snap_fe = fe_cnt;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic pflip, input logic stop);
    return {stop, (~^d) ^ pflip, d, 1'b0};
  endfunction

  // Sends the first nbits bits of a frame; a bit period is 120 cycles.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      PS2_DAT = bits[i];
      wait_cyc(30);
      PS2_CLK   = 1'b0;
      last_fall = cyc;
      if (glitch) begin
        wait_cyc(20);
        PS2_DAT = ~bits[i];
        wait_cyc(15);
        PS2_DAT = bits[i];
        wait_cyc(25);
      end else begin
        wait_cyc(60);
      end
      PS2_CLK = 1'b1;
      wait_cyc(30);
    end
    PS2_DAT = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pflip;
    logic       stop;
    logic [7:0] exp_scan;
    logic       exp_sv;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'hF0, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h5A, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'hE0, 1'b0, 1'b1, 8'hE0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h5A, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{8'hA5, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1};

    #5;
    chk("reset_scan", 32'(SCAN), 32'h00);
    chk("reset_sv", 32'(SCAN_VALID), 32'h0);
    chk("reset_pe", 32'(PARITY_ERR), 32'h0);
    chk("reset_fe", 32'(FRAME_ERR), 32'h0);
    wait_cyc(5);
    RESET_N = 1'b1;
    wait_cyc(40);

    for (int v = 0; v < 9; v++) begin
      snap();
      send_bits(mk_frame(vecs[v].data, vecs[v].pflip, vecs[v].stop), 11, 1'b0);
      wait_cyc(40);
      $display("vec %0d data=%02h pflip=%0d stop=%0d scan=%02h sv=%0d pe=%0d fe=%0d", v,
               vecs[v].data, vecs[v].pflip, vecs[v].stop, SCAN,
               sv_cnt - snap_sv, pe_cnt - snap_pe, fe_cnt - snap_fe);
      chk($sformatf("vec%0d_scan", v), 32'(SCAN), 32'(vecs[v].exp_scan));
      chk($sformatf("vec%0d_sv", v), sv_cnt - snap_sv, 32'(vecs[v].exp_sv));
      chk($sformatf("vec%0d_pe", v), pe_cnt - snap_pe, 32'(vecs[v].exp_pe));
      chk($sformatf("vec%0d_fe", v), fe_cnt - snap_fe, 32'(vecs[v].exp_fe));
      if (vecs[v].exp_sv) chk_rng($sformatf("vec%0d_lat", v), sv_cyc - last_fall, LAT - 1, LAT + 1);
      if (vecs[v].exp_pe) chk_rng($sformatf("vec%0d_lat", v), pe_cyc - last_fall, LAT - 1, LAT + 1);
      if (vecs[v].exp_fe) chk_rng($sformatf("vec%0d_lat", v), fe_cyc - last_fall, LAT - 1, LAT + 1);
    end

    // Clock stalls after four data bits.
    snap();
    send_bits(mk_frame(8'h29, 1'b0, 1'b1), 5, 1'b0);
    wait_cyc(TMO + 100);
    $display("timeout: fe=%0d lat=%0d scan=%02h", fe_cnt - snap_fe, fe_cyc - last_fall, SCAN);
    chk("tmo_fe", fe_cnt - snap_fe, 1);
    chk_rng("tmo_lat", fe_cyc - last_fall, LAT + TMO - 1, LAT + TMO + 1);
    chk("tmo_sv", sv_cnt - snap_sv, 0);
    chk("tmo_scan", 32'(SCAN), 32'h5A);
    snap();
    send_bits(mk_frame(8'h29, 1'b0, 1'b1), 11, 1'b0);
    wait_cyc(40);
    $display("after timeout: scan=%02h sv=%0d", SCAN, sv_cnt - snap_sv);
    chk("post_tmo_scan", 32'(SCAN), 32'h29);
    chk("post_tmo_sv", sv_cnt - snap_sv, 1);

    // Short clock glitches with data low would start a bogus frame if they leaked.
    snap();
    PS2_DAT = 1'b0;
    wait_cyc(30);
    for (int g = 0; g < 5; g++) begin
      PS2_CLK = 1'b0;
      wait_cyc(8);
      PS2_CLK = 1'b1;
      wait_cyc(40);
    end
    PS2_DAT = 1'b1;
    wait_cyc(TMO + 50);
    $display("clk glitches: sv=%0d pe=%0d fe=%0d", sv_cnt - snap_sv, pe_cnt - snap_pe, fe_cnt - snap_fe);
    chk("glitch_idle_evts", (sv_cnt - snap_sv) + (pe_cnt - snap_pe) + (fe_cnt - snap_fe), 0);
    snap();
    send_bits(mk_frame(8'h3A, 1'b0, 1'b1), 11, 1'b1);
    wait_cyc(40);
    $display("dat glitch frame: scan=%02h sv=%0d pe=%0d fe=%0d", SCAN,
             sv_cnt - snap_sv, pe_cnt - snap_pe, fe_cnt - snap_fe);
    chk("glitch_frame_scan", 32'(SCAN), 32'h3A);
    chk("glitch_frame_sv", sv_cnt - snap_sv, 1);
    chk("glitch_frame_err", (pe_cnt - snap_pe) + (fe_cnt - snap_fe), 0);

    // Reset asserted while bit 5 is on the line.
    snap();
    send_bits(mk_frame(8'h29, 1'b0, 1'b1), 6, 1'b0);
    PS2_DAT = 1'b1;
    wait_cyc(10);
    #3 RESET_N = 1'b0;
    #1;
    $display("mid-frame reset: scan=%02h sv=%0d pe=%0d fe=%0d", SCAN, SCAN_VALID, PARITY_ERR, FRAME_ERR);
    chk("rst_async_scan", 32'(SCAN), 32'h00);
    chk("rst_async_pulses", 32'({SCAN_VALID, PARITY_ERR, FRAME_ERR}), 32'h0);
    wait_cyc(5);
    RESET_N = 1'b1;
    wait_cyc(2 * TMO);
    chk("rst_no_pulses", (sv_cnt - snap_sv) + (pe_cnt - snap_pe) + (fe_cnt - snap_fe), 0);
    snap();
    send_bits(mk_frame(8'h16, 1'b0, 1'b1), 11, 1'b0);
    wait_cyc(40);
    $display("after reset: scan=%02h sv=%0d", SCAN, sv_cnt - snap_sv);
    chk("post_rst_scan", 32'(SCAN), 32'h16);
    chk("post_rst_sv", sv_cnt - snap_sv, 1);

    chk("pulse_width", wide_cnt, 0);
    chk("pulse_exclusive", excl_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
Front end of the keyboard path. It synchronises and deglitches the raw PS2_CLK/PS2_DAT lines and deserialises 11-bit PS/2 device-to-host frames. It checks the start, parity and stop bits and enforces an inter-bit timeout. It presents each good scan code as a byte plus a one-cycle valid pulse to the downstream scan-code-to-ASCII decoder, with separate error pulses for diagnostics.

Parameters:
FILTER_LEN, 16, consecutive identical synchronised samples required before a filtered line changes level
TIMEOUT_CYC, 100000, CLOCK_50 cycles (2 ms) allowed between filtered falling edges inside a frame

Ports:
CLOCK_50  input  1  system clock, 50 MHz
RESET_N  input  1  reset, asynchronous assert, active-low
PS2_CLK  input  1  raw PS/2 clock line, asynchronous
PS2_DAT  input  1  raw PS/2 data line, asynchronous
SCAN  output  8  last correctly received scan code
SCAN_VALID  output  1  one-cycle pulse; SCAN updated this cycle
PARITY_ERR  output  1  one-cycle pulse; frame discarded for bad odd parity
FRAME_ERR  output  1  one-cycle pulse; frame discarded for bad stop bit or timeout

Behaviour:
- Reset (RESET_N low, async): SCAN=8'h00, SCAN_VALID=0, PARITY_ERR=0, FRAME_ERR=0, state=IDLE, filtered clk=1, filtered dat=1, filter counters=0, timeout counter=0.
- Input conditioning, identical per line:
  - 2-flop synchroniser.
  - Filter: counter increments while the synced sample differs from the filtered level and clears when it matches.
  - When the counter reaches FILTER_LEN-1 with a differing sample, the filtered level flips and the counter clears.
  - Pulses shorter than FILTER_LEN cycles never reach the filtered output.
- Falling edge (fall) = filtered clk was 1 last cycle and is 0 this cycle. The data bit is the filtered dat in the same cycle. Both lines share the same pipeline latency, so they stay aligned.
- FSM, advances only on fall:
  - IDLE: dat=0 (start bit) -> DATA, bit index=0. dat=1 -> stay IDLE, no error.
  - DATA: shift dat in LSB-first into data[index]. After index 7 -> PARITY.
  - PARITY: capture parity bit -> STOP.
  - STOP: evaluate the frame -> IDLE.
- Frame evaluation, on the STOP fall:
  - stop bit=0 -> FRAME_ERR pulse. PARITY_ERR not asserted, even if parity is also bad.
  - else popcount(data, parity) even -> PARITY_ERR pulse.
  - else SCAN<=data and SCAN_VALID pulse.
  - All outputs update in the cycle after the stop-bit fall. This is a registered output: latency is 1 CLOCK_50 after fall.
  - SCAN is unchanged on any error.
- Timeout:
  - The counter clears on every fall and in IDLE, and increments otherwise.
  - In DATA, PARITY or STOP, reaching TIMEOUT_CYC-1 -> state=IDLE, FRAME_ERR pulse, partial data discarded.
- Pulses are mutually exclusive and each lasts exactly 1 cycle. At most one pulse per frame.
- Back-to-back frames: a start-bit fall in the cycle after the stop evaluation is accepted normally, with no dead time.
- Reset mid-frame: the frame is abandoned, no pulse is emitted, and reception resumes at the next start bit after release.
- Width rules: bit index 3 bits; filter counter clog2(FILTER_LEN) bits; timeout counter clog2(TIMEOUT_CYC) bits; no wrap can occur because all counters are bounded.

Decomposition:
- ps2_pkg:
  - state enum (IDLE, DATA, PARITY, STOP)
  - PS2_FRAME_BITS=11
  - default FILTER_LEN/TIMEOUT_CYC constants
  - shared with the downstream decoder, which also uses its scan-code constants 8'hF0 (break) and 8'hE0 (extended)
- Sub-module ps2_line_filter: synchroniser + filter, parameter FILTER_LEN, ports CLOCK_50, RESET_N, raw, filtered. Instantiated twice, once for clk and once for dat.
- FSM, shifter, parity and timeout logic live in ps2_rx_frame.

Test Plan:
- Frame for 8'h1C (start 0, data 0,0,1,1,1,0,0,0 LSB-first, parity 0, stop 1) at 12.5 kHz -> SCAN=8'h1C, SCAN_VALID high exactly 1 cycle, 1 cycle after the stop fall, no error pulses.
- Same frame with parity bit=1 -> PARITY_ERR 1 cycle, SCAN keeps its prior value, no SCAN_VALID. Then a good 8'hF0 frame -> SCAN=8'hF0, SCAN_VALID.
- Frame 8'h5A with stop bit=0 and parity also wrong -> FRAME_ERR only, PARITY_ERR stays 0.
- Clock stops after 4 data bits -> FRAME_ERR at TIMEOUT_CYC cycles after the last fall. A following complete 8'h29 frame -> SCAN=8'h29.
- 8-cycle low glitches on PS2_CLK while idle, plus 15-cycle glitches on PS2_DAT mid-bit -> no state change, and the frame decodes correctly.
- RESET_N pulsed low during bit 5 of a frame -> all outputs 0 immediately (async), no pulses after release. The next frame, 8'h16, decodes to SCAN=8'h16.
